// File: rtl/seq_alu_md.sv
// seq_alu_md: multi-cycle ALU with a wide X operand (2W+1 bits) and a narrow
// Y operand (W bits). PASS/ADD/SUB/SHL/SHR complete in one cycle. MUL
// (shift-add) and DIV (restoring) take W RUN cycles. A start/busy/done
// handshake sequences the operations. The Z/Bo/eqz/err outputs are
// registered and hold their value until the next done pulse.
module seq_alu_md #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [3:0]     func_sel,
    input  logic [2*W:0]   X,
    input  logic [W-1:0]   Y,
    output logic [2*W:0]   Z,
    output logic           Bo,
    output logic           eqz,
    output logic           err,
    output logic           busy,
    output logic           done
);

    localparam int XW = 2 * W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_PASS = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SHL  = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_DIV  = 4'd6;

    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    // Sequencer state
    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_is_div;

    // Multiply datapath: the multiplicand shifts left, the multiplier shifts right
    logic [2*W-1:0]  r_mcand;
    logic [W-1:0]    r_mplier;
    logic [2*W-1:0]  r_acc;

    // Divide datapath. The remainder stays below the divisor, so W bits hold it.
    // The trial value is W+1 bits wide.
    logic [W-1:0]    r_rem;
    logic [W-1:0]    r_quo;
    logic [W-1:0]    r_divisor;

    // Issue-time (single-cycle) results
    logic [XW-1:0]   w_y_ext;
    logic [XW:0]     w_sum;
    logic [XW-1:0]   w_diff;
    logic            w_div_err;
    logic [XW-1:0]   w_imm_z;
    logic            w_imm_bo;
    logic            w_imm_err;
    logic            w_go_run;

    // Iteration step values
    logic [2*W-1:0]  w_acc_next;
    logic [W:0]      w_trial;
    logic [W-1:0]    w_sub;
    logic            w_qbit;
    logic [W-1:0]    w_rem_next;
    logic [W-1:0]    w_quo_next;
    logic [XW-1:0]   w_iter_z;

    // Result write control
    logic            w_issue;
    logic            w_last;
    logic            w_load;
    logic [XW-1:0]   w_z_next;
    logic            w_bo_next;
    logic            w_err_next;

    // Decode func_sel and compute the one-cycle result and the DIV error check
    always_comb begin
        w_y_ext   = {{(W + 1){1'b0}}, Y};
        w_sum     = {1'b0, X} + {1'b0, w_y_ext};
        w_diff    = X - w_y_ext;
        w_div_err = (Y == '0) || (X[2*W:W] >= {1'b0, Y});
        w_imm_z   = '0;
        w_imm_bo  = 1'b0;
        w_imm_err = 1'b0;
        w_go_run  = 1'b0;
        case (func_sel)
            OP_PASS: w_imm_z = X;
            OP_ADD: begin
                w_imm_z  = w_sum[XW-1:0];
                w_imm_bo = w_sum[XW];
            end
            OP_SUB: begin
                w_imm_z  = w_diff;
                w_imm_bo = (X < w_y_ext);
            end
            OP_SHL: begin
                w_imm_z  = {X[2*W-1:0], 1'b0};
                w_imm_bo = X[2*W];
            end
            OP_SHR: begin
                w_imm_z  = {1'b0, X[2*W:1]};
                w_imm_bo = X[0];
            end
            OP_MUL: w_go_run = 1'b1;
            OP_DIV: begin
                if (w_div_err) begin
                    w_imm_z   = '1;
                    w_imm_bo  = 1'b1;
                    w_imm_err = 1'b1;
                end else begin
                    w_go_run = 1'b1;
                end
            end
            default: w_imm_err = 1'b1;
        endcase
    end

    // Compute one shift-add step and one restoring-divide step from the current registers
    always_comb begin
        w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
        w_trial    = {r_rem, r_quo[W-1]};
        w_qbit     = (w_trial >= {1'b0, r_divisor});
        // When the subtraction is kept, the difference is below the divisor,
        // so the low W bits of the trial give the exact result.
        w_sub      = w_trial[W-1:0] - r_divisor;
        w_rem_next = w_qbit ? w_sub : w_trial[W-1:0];
        w_quo_next = {r_quo[W-2:0], w_qbit};
        w_iter_z   = r_is_div ? {1'b0, w_rem_next, w_quo_next}
                              : {1'b0, w_acc_next};
    end

    // Select the value written into Z/flags and when to write it
    always_comb begin
        w_issue    = (r_state == S_IDLE) && start;
        w_last     = (r_cnt == CNT_LAST);
        w_load     = (w_issue && !w_go_run) || ((r_state == S_RUN) && w_last);
        w_z_next   = (r_state == S_RUN) ? w_iter_z : w_imm_z;
        w_bo_next  = (r_state == S_RUN) ? 1'b0 : w_imm_bo;
        w_err_next = (r_state == S_RUN) ? 1'b0 : w_imm_err;
    end

    // Sequencer FSM, operand latching and the iterative datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt     <= '0;
                        r_is_div  <= (func_sel == OP_DIV);
                        r_mcand   <= {{W{1'b0}}, X[W-1:0]};
                        r_mplier  <= Y;
                        r_acc     <= '0;
                        r_rem     <= X[2*W-1:W];
                        r_quo     <= X[W-1:0];
                        r_divisor <= Y;
                        r_state   <= w_go_run ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_rem    <= w_rem_next;
                    r_quo    <= w_quo_next;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Result register and flags, updated only when a result completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Z   <= '0;
            Bo  <= 1'b0;
            eqz <= 1'b1;
            err <= 1'b0;
        end else if (w_load) begin
            Z   <= w_z_next;
            Bo  <= w_bo_next;
            eqz <= (w_z_next == '0);
            err <= w_err_next;
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

endmodule

// File: doc/seq_alu_md.md
Name: seq_alu_md

Overview:
Parametrised multi-cycle ALU for the datapath. Wide X operand (2W+1 bits), narrow Y operand (W bits), 4-bit func_sel, registered Z/Bo/eqz flags.
- Single-cycle ops: pass, add, subtract, shift.
- Iterative ops: shift-add multiply and restoring divide.
- Sequencing via a start/busy/done handshake so the controller FSM can issue operations back to back.

Parameters:
W, 8, narrow operand width. X and Z are 2W+1 bits wide (17 at default); Y is W bits.
CW, 4, iteration counter width. Must satisfy 2^CW > W.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request; sampled only in IDLE
func_sel  input  4  operation select, sampled with start
X  input  2W+1  wide operand, sampled with start
Y  input  W  narrow operand, sampled with start
Z  output  2W+1  registered result
Bo  output  1  registered borrow/carry flag
eqz  output  1  registered flag, high when Z == 0
err  output  1  registered flag for divide-by-zero or quotient overflow
busy  output  1  high in RUN state
done  output  1  one-cycle pulse when Z/flags become valid

Behaviour:
- One clock; reset is asynchronous and active-high.
- While rst is asserted: state=IDLE, Z=0, Bo=0, eqz=1, err=0, busy=0, done=0, iteration counter=0.
- Flags are sticky: Z/Bo/eqz/err hold their value until the next done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1, single-cycle op → DONE.
  - IDLE, start=1, MUL/DIV → RUN. Operands are latched on this edge.
  - RUN → RUN until the counter reaches W-1, then → DONE.
  - DONE → IDLE unconditionally. done=1 only in DONE.
- Latency, counted from the start edge to the first cycle with done=1:
  - 1 cycle for single-cycle ops and for MUL/DIV error exits.
  - W+1 cycles for MUL/DIV.
  - Back-to-back throughput: a new start is accepted in the cycle after done.
- start is ignored in RUN and DONE: no restart, and latched operands are unaffected. func_sel/X/Y may change freely while busy.
- func_sel encodings. Y is zero-extended to 2W+1 bits where needed.
  - 0 PASS: Z=X, Bo=0.
  - 1 ADD: Z=X+Y modulo 2^(2W+1); Bo=carry out of bit 2W.
  - 2 SUB: Z=X−Y modulo 2^(2W+1); Bo=1 iff X<Y (unsigned).
  - 3 SHL: Z={X[2W-1:0],0}; Bo=X[2W].
  - 4 SHR: Z={0,X[2W:1]}; Bo=X[0].
  - 5 MUL: Z={0, X[W-1:0]*Y}, computed by shift-add, one partial product per RUN cycle. Bo=0. X[2W:W] is ignored.
  - 6 DIV: restoring division of X[2W-1:0] by Y, one quotient bit per RUN cycle. Z={0, remainder[W-1:0], quotient[W-1:0]}. Bo=0.
  - 7–15: Z=0, err=1, latency 1.
- DIV errors are checked at start and skip RUN (latency 1). In both cases Z=all ones, err=1, Bo=1.
  - Y==0: divide-by-zero.
  - X[2W:W] >= Y: quotient does not fit in W bits, reported as overflow.
- err=0 for every successful operation.
- eqz is computed from the value being written into Z, so it is valid in the same cycle as done.
- Internal accumulator is wide enough for no intermediate truncation: partial remainder W+1 bits, product 2W bits.
- Reset mid-operation aborts immediately: next state IDLE, all outputs return to reset values, and no done pulse is produced for the aborted op.

Test Plan:
- Reset and flags: assert rst during RUN of a DIV (X=1000, Y=7) → busy=0, Z=0, eqz=1 immediately. After release, no done pulse for the aborted op; the next op runs normally.
- SUB with borrow: start, func_sel=2, X=1, Y=2 → one cycle later done=1, Z=17'h1FFFF, Bo=1, eqz=0, err=0.
- SUB to zero: X=8, Y=1 → Z=7, Bo=0. Then X=5, Y=5 → Z=0, eqz=1, Bo=0.
- MUL worst case: func_sel=5, X=255, Y=255 → done exactly 9 cycles after start, Z=17'h0FE01, busy high for 8 cycles. A second start pulsed mid-RUN is ignored.
- DIV normal: func_sel=6, X=1000, Y=7 → done at 9 cycles, Z=17'h0068E (remainder 6, quotient 142), err=0. Issue back to back with ADD X=17'h1FFFF, Y=1 → Z=0, Bo=1, eqz=1.
- DIV errors: Y=0 → 1-cycle latency, Z=17'h1FFFF, err=1, Bo=1. Then X=17'h00800, Y=8 → overflow, err=1. Then func_sel=9 → Z=0, err=1, eqz=1.
